// File: rtl/zigzag_quant_unit.sv
// zigzag_quant_unit: loads one 8x8 block of coefficients from the host write
// area, quantizes each coefficient with the JPEG luminance table (or passes it
// through in bypass), reorders the block into zigzag order and exposes the
// result buffer combinationally on data_out for the host to copy out.
//
// Handshake: there is no valid/ready pair. The host holds start high to
// request a run; the block walks IDLE->LOAD->PROCESS->SAVE->DONE with fixed
// cycle counts. It returns to IDLE only after start has been seen low in DONE.
// data_in is expected to be valid in the same cycle as data_in_addr.
module zigzag_quant_unit #(
  parameter int N_COEF  = 64,
  parameter int RECIP_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        bypass,
  output logic [7:0]  data_in_addr,
  input  logic [31:0] data_in,
  input  logic [7:0]  data_out_addr,
  output logic [31:0] data_out,
  output logic [3:0]  state_out
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LOAD = 4'd1,
    S_PROC = 4'd2,
    S_SAVE = 4'd3,
    S_DONE = 4'd4
  } state_t;

  // Zigzag position -> natural (row-major) index.
  localparam logic [5:0] ZZ [N_COEF] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  // Luminance quantizer step sizes, natural order.
  localparam int Q_LUM [N_COEF] = '{
    16, 11, 10, 16,  24,  40,  51,  61,
    12, 12, 14, 19,  26,  58,  60,  55,
    14, 13, 16, 24,  40,  57,  69,  56,
    14, 17, 22, 29,  51,  87,  80,  62,
    18, 22, 37, 56,  68, 109, 103,  77,
    24, 35, 55, 64,  81, 104, 113,  92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103,  99
  };

  // Rounded reciprocals round(65536/Q) folded to constants at elaboration.
  logic [RECIP_W-1:0] recip_rom [N_COEF];
  for (genvar g = 0; g < N_COEF; g++) begin : g_recip
    assign recip_rom[g] = RECIP_W'((65536 + Q_LUM[g] / 2) / Q_LUM[g]);
  end

  state_t             state_q, state_d;
  logic [5:0]         addr_q, addr_d;
  logic [6:0]         cnt_q, cnt_d;
  logic               byp_q, byp_d;
  logic [15:0]        in_buf_q [N_COEF];
  logic [15:0]        in_buf_d [N_COEF];
  logic [31:0]        out_buf_q [N_COEF];
  logic [31:0]        out_buf_d [N_COEF];
  logic               s1_v_q, s1_v_d;
  logic [5:0]         s1_idx_q, s1_idx_d;
  logic signed [15:0] s1_x_q, s1_x_d;
  logic [RECIP_W-1:0] s1_r_q, s1_r_d;

  logic signed [32:0] prod;
  logic signed [32:0] rnd;
  logic [31:0]        result;

  // Only the signed low half of each input word and the low six address bits matter.
  logic unused_bits;
  assign unused_bits = &{1'b0, data_in[31:16], data_out_addr[7:6]};

  assign data_in_addr = {2'b00, addr_q};
  assign data_out     = out_buf_q[data_out_addr[5:0]];
  assign state_out    = state_q;

  // Stage 2 arithmetic: multiply by reciprocal, round half up, keep the integer part.
  always_comb begin
    prod   = 33'(s1_x_q) * $signed({17'd0, s1_r_q});
    rnd    = prod + 33'sd32768;
    result = byp_q ? {{16{s1_x_q[15]}}, s1_x_q} : {{15{rnd[32]}}, rnd[32:16]};
  end

  // Next-state, address/counter sequencing, buffer writes and stage-1 issue.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    byp_d     = byp_q;
    in_buf_d  = in_buf_q;
    out_buf_d = out_buf_q;
    s1_v_d    = 1'b0;
    s1_idx_d  = s1_idx_q;
    s1_x_d    = s1_x_q;
    s1_r_d    = s1_r_q;
    if (s1_v_q) begin
      out_buf_d[s1_idx_q] = result;
    end
    case (state_q)
      S_IDLE: begin
        addr_d = 6'd0;
        cnt_d  = 7'd0;
        if (start) begin
          state_d = S_LOAD;
          byp_d   = bypass;
        end
      end
      S_LOAD: begin
        in_buf_d[addr_q] = data_in[15:0];
        if (addr_q == 6'd63) begin
          addr_d  = 6'd0;
          cnt_d   = 7'd0;
          state_d = S_PROC;
        end else begin
          addr_d = addr_q + 6'd1;
        end
      end
      S_PROC: begin
        if (!cnt_q[6]) begin
          s1_v_d   = 1'b1;
          s1_idx_d = cnt_q[5:0];
          s1_x_d   = $signed(in_buf_q[ZZ[cnt_q[5:0]]]);
          s1_r_d   = recip_rom[ZZ[cnt_q[5:0]]];
          cnt_d    = cnt_q + 7'd1;
        end else begin
          cnt_d   = 7'd0;
          state_d = S_SAVE;
        end
      end
      S_SAVE: begin
        if (cnt_q == 7'd63) begin
          cnt_d   = 7'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset clears everything including both buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= 6'd0;
      cnt_q     <= 7'd0;
      byp_q     <= 1'b0;
      in_buf_q  <= '{default: '0};
      out_buf_q <= '{default: '0};
      s1_v_q    <= 1'b0;
      s1_idx_q  <= 6'd0;
      s1_x_q    <= 16'sd0;
      s1_r_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      byp_q     <= byp_d;
      in_buf_q  <= in_buf_d;
      out_buf_q <= out_buf_d;
      s1_v_q    <= s1_v_d;
      s1_idx_q  <= s1_idx_d;
      s1_x_q    <= s1_x_d;
      s1_r_q    <= s1_r_d;
    end
  end

endmodule

// File: tb/tb_zigzag_quant_unit.sv
// Bench for zigzag_quant_unit: a host-memory model feeds data_in, a reference
// model computes zigzag/quantized results, and a monitor compares data_out
// against an expected queue during readback.
module tb_zigzag_quant_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        bypass;
  logic [7:0]  data_in_addr;
  logic [31:0] data_in;
  logic [7:0]  data_out_addr;
  logic [31:0] data_out;
  logic [3:0]  state_out;

  logic [31:0] host_mem [64];
  logic [31:0] exp_q [$];
  bit          rd_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          zz_tab [64];
  int          q_lum  [64] = '{
    16, 11, 10, 16,  24,  40,  51,  61,
    12, 12, 14, 19,  26,  58,  60,  55,
    14, 13, 16, 24,  40,  57,  69,  56,
    14, 17, 22, 29,  51,  87,  80,  62,
    18, 22, 37, 56,  68, 109, 103,  77,
    24, 35, 55, 64,  81, 104, 113,  92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103,  99
  };

  zigzag_quant_unit dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .bypass        (bypass),
    .data_in_addr  (data_in_addr),
    .data_in       (data_in),
    .data_out_addr (data_out_addr),
    .data_out      (data_out),
    .state_out     (state_out)
  );

  // clock / host read port
  always #5 clk = ~clk;
  assign data_in = host_mem[data_in_addr[5:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Zigzag walk over anti-diagonals: even diagonals go up-right, odd go down-left.
  function automatic void build_zz();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int rlo = (s > 7) ? s - 7 : 0;
      int rhi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = rhi; r >= rlo; r--) begin zz_tab[n] = r * 8 + (s - r); n++; end
      end else begin
        for (int r = rlo; r <= rhi; r++) begin zz_tab[n] = r * 8 + (s - r); n++; end
      end
    end
  endfunction

  // Reference: result for zigzag slot i from the current host memory.
  function automatic logic [31:0] model(input int i, input bit byp);
    int k = zz_tab[i];
    logic signed [15:0] xs = host_mem[k][15:0];
    int x = xs;
    real r, y;
    if (byp) return 32'(x);
    r = $floor(65536.0 / q_lum[k] + 0.5);
    y = $floor(real'(x) * r / 65536.0 + 0.5);
    return 32'($rtoi(y));
  endfunction

  // monitor: pop the expected queue whenever the bench presents a read
  always @(negedge clk) begin
    if (rd_en) begin
      if (exp_q.size() == 0) begin
        chk("exp_q underflow", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk($sformatf("data_out[0x%02h]", data_out_addr), data_out, e);
      end
    end
  end

  task automatic read_one(input logic [7:0] a, input logic [31:0] e);
    @(posedge clk); #1;
    data_out_addr = a;
    rd_en = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic readback(input bit byp, input bit zero);
    for (int i = 0; i < 64; i++) read_one(8'(i), zero ? 32'd0 : model(i, byp));
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  // One full run: checks state sequence, load addresses and total latency.
  task automatic run(input bit byp, input bit drop);
    int n1 = 0, n2 = 0, n3 = 0, bud = 0;
    bit seen_done = 0, addr_ok = 1, order_ok = 1;
    logic [3:0] prev = 4'd0;
    @(posedge clk); #1;
    start = 1'b1;
    bypass = byp;
    while (!seen_done && bud < 400) begin
      @(negedge clk);
      bud++;
      if (state_out < prev) order_ok = 0;
      prev = state_out;
      case (state_out)
        4'd1: begin
          if (data_in_addr != 8'(n1)) addr_ok = 0;
          n1++;
          if (drop && n1 == 10) start = 1'b0;
        end
        4'd2: n2++;
        4'd3: n3++;
        4'd4: seen_done = 1;
        default: ;
      endcase
    end
    chk("done reached", 32'(seen_done), 32'd1);
    chk("load cycles", n1, 64);
    chk("process cycles", n2, 65);
    chk("save cycles", n3, 64);
    chk("load addr sequence", 32'(addr_ok), 32'd1);
    chk("state order", 32'(order_ok), 32'd1);
    chk("start-to-done cycles", bud - 1, 194);
    if (drop) begin
      @(negedge clk);
      chk("idle after done", 32'(state_out), 32'd0);
    end else begin
      repeat (4) @(negedge clk);
      chk("hold in done", 32'(state_out), 32'd4);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle after start low", 32'(state_out), 32'd0);
    end
  endtask

  task automatic fill_random();
    for (int n = 0; n < 64; n++) host_mem[n] = $urandom;
  endtask

  initial begin
    build_zz();
    start = 1'b0;
    bypass = 1'b0;
    data_out_addr = 8'd0;
    for (int n = 0; n < 64; n++) host_mem[n] = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset state", 32'(state_out), 32'd0);
    chk("reset data_in_addr", 32'(data_in_addr), 32'd0);
    chk("reset data_out", data_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ramp, bypass
    for (int n = 0; n < 64; n++) host_mem[n] = 32'(n);
    run(1'b1, 1'b0);
    readback(1'b1, 1'b0);
    read_one(8'h47, model(7, 1'b1));
    read_one(8'd5, 32'd2);
    read_one(8'd63, 32'd63);
    @(posedge clk); #1; rd_en = 1'b0;

    // constant 160, quantized; plain-constant spot checks too
    for (int n = 0; n < 64; n++) host_mem[n] = 32'd160;
    run(1'b0, 1'b0);
    readback(1'b0, 1'b0);
    read_one(8'd0, 32'd10);
    read_one(8'd1, 32'd15);
    read_one(8'd2, 32'd13);
    read_one(8'd63, 32'd2);
    @(posedge clk); #1; rd_en = 1'b0;

    // negative rounding, with start dropped during LOAD
    for (int n = 0; n < 64; n++) host_mem[n] = 32'd0;
    host_mem[0] = 32'hFFFF_FFE8;
    run(1'b0, 1'b1);
    read_one(8'd0, 32'hFFFF_FFFF);
    @(posedge clk); #1; rd_en = 1'b0;
    host_mem[0] = 32'h0001_FFF8;
    run(1'b0, 1'b1);
    readback(1'b0, 1'b0);

    // random blocks
    fill_random();
    run(1'b0, 1'b0);
    readback(1'b0, 1'b0);
    fill_random();
    run(1'b1, 1'b1);
    readback(1'b1, 1'b0);

    // reset at PROCESS cycle 30
    fill_random();
    begin
      int pc = 0, bud = 0;
      @(posedge clk); #1;
      start = 1'b1;
      bypass = 1'b0;
      while (pc < 30 && bud < 400) begin
        @(negedge clk);
        bud++;
        if (state_out == 4'd2) pc++;
      end
      chk("reached process cycle 30", pc, 30);
      rst = 1'b1;
      @(negedge clk);
      chk("state after mid reset", 32'(state_out), 32'd0);
      chk("data_in_addr after mid reset", 32'(data_in_addr), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
    end
    readback(1'b0, 1'b1);
    fill_random();
    run(1'b0, 1'b0);
    readback(1'b0, 1'b0);

    repeat (2) @(posedge clk);
    chk("exp_q drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
